// File: rtl/gb_timer_pkg.sv
// ---------------------------------------------------------------------------
// gb_timer_pkg
// Shared definitions for the DIV/TIMA/TMA/TAC timer block:
//   - reg_addr_e    : register select encoding on addr_in
//   - timer_state_e : overflow-handling state (RUN / OVF_PEND)
//   - TAC_BIT_SELx  : sys_cnt bit tapped for each TAC[1:0] clock select
//   - tac_tap()     : returns the selected sys_cnt bit for a given select
// ---------------------------------------------------------------------------
package gb_timer_pkg;

  typedef enum logic [1:0] {
    ADDR_DIV  = 2'd0,
    ADDR_TIMA = 2'd1,
    ADDR_TMA  = 2'd2,
    ADDR_TAC  = 2'd3
  } reg_addr_e;

  typedef enum logic {
    RUN      = 1'b0,
    OVF_PEND = 1'b1
  } timer_state_e;

  // sys_cnt bit observed by the timer for each TAC[1:0] value.
  localparam int unsigned TAC_BIT_SEL0 = 9;
  localparam int unsigned TAC_BIT_SEL1 = 3;
  localparam int unsigned TAC_BIT_SEL2 = 5;
  localparam int unsigned TAC_BIT_SEL3 = 7;

  // Unimplemented TAC bits read back as ones.
  localparam logic [4:0] TAC_READ_PAD = 5'b11111;

  function automatic logic tac_tap(input logic [15:0] cnt, input logic [1:0] sel);
    logic tap;
    tap = 1'b0;
    unique case (sel)
      2'b00: tap = cnt[TAC_BIT_SEL0];
      2'b01: tap = cnt[TAC_BIT_SEL1];
      2'b10: tap = cnt[TAC_BIT_SEL2];
      2'b11: tap = cnt[TAC_BIT_SEL3];
    endcase
    return tap;
  endfunction

endpackage

// File: rtl/gb_timer.sv
// ---------------------------------------------------------------------------
// gb_timer
// Programmable timer: a 16-bit free-running system counter (DIV is its upper
// byte) clocks TIMA on falling edges of a TAC-selected counter bit. A TIMA
// overflow reads as 0x00 until the next machine-cycle tick, at which point
// TIMA reloads from TMA and a one-clock interrupt pulse is issued.
//
// Parameters
//   CNT_STEP  : sys_cnt increment per tick_in
// Ports
//   clk_in    : system clock
//   rst_in    : synchronous active-high reset
//   tick_in   : one-clock machine-cycle strobe
//   addr_in   : register select (0=DIV, 1=TIMA, 2=TMA, 3=TAC)
//   wr_en_in  : register write strobe
//   wdata_in  : register write data
//   rdata_out : combinational read of the selected register
//   irq_out   : one-clock timer interrupt request
// ---------------------------------------------------------------------------
module gb_timer #(
  parameter int unsigned CNT_STEP = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tick_in,
  input  logic [1:0] addr_in,
  input  logic       wr_en_in,
  input  logic [7:0] wdata_in,
  output logic [7:0] rdata_out,
  output logic       irq_out
);

  import gb_timer_pkg::*;

  localparam logic [15:0] STEP16 = 16'(CNT_STEP);

  reg_addr_e    reg_sel;
  logic         wr_div, wr_tima, wr_tma, wr_tac;

  logic [15:0]  sys_cnt;
  logic [2:0]   tac;
  logic [7:0]   tma;
  logic [7:0]   tima, tima_nxt;
  timer_state_e state, state_nxt;
  logic         irq_q, irq_nxt;

  logic         timer_in;    // enable AND selected counter bit, this clock
  logic         edge_q;      // timer_in as it was on the previous clock
  logic         timer_fall;

  assign reg_sel = reg_addr_e'(addr_in);
  assign wr_div  = wr_en_in && (reg_sel == ADDR_DIV);
  assign wr_tima = wr_en_in && (reg_sel == ADDR_TIMA);
  assign wr_tma  = wr_en_in && (reg_sel == ADDR_TMA);
  assign wr_tac  = wr_en_in && (reg_sel == ADDR_TAC);

  // Because timer_in is formed from the live register values, a DIV clear,
  // an enable clear or a select change all look like an ordinary falling
  // edge and bump TIMA one clock later, just like counter-driven edges.
  assign timer_in   = tac[2] && tac_tap(sys_cnt, tac[1:0]);
  assign timer_fall = edge_q && !timer_in;

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: reset is synchronous -- it only acts at a clock edge, so it
  // lives inside the edge-triggered branch rather than the sensitivity list.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sys_cnt <= '0;
      tac     <= '0;
      tma     <= '0;
      edge_q  <= 1'b0;
    end else begin
      edge_q <= timer_in;
      // A DIV write wins over a same-cycle increment.
      if (wr_div)       sys_cnt <= '0;
      else if (tick_in) sys_cnt <= sys_cnt + STEP16;
      if (wr_tac) tac <= wdata_in[2:0];
      if (wr_tma) tma <= wdata_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= RUN;
      tima  <= '0;
      irq_q <= 1'b0;
    end else begin
      state <= state_nxt;
      tima  <= tima_nxt;
      irq_q <= irq_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    tima_nxt  = tima;
    irq_nxt   = 1'b0;
    unique case (state)
      RUN: begin
        if (wr_tima) begin
          tima_nxt = wdata_in;
        end else if (timer_fall) begin
          if (tima == 8'hFF) begin
            tima_nxt  = 8'h00;
            state_nxt = OVF_PEND;
          end else begin
            tima_nxt = tima + 8'd1;
          end
        end
      end
      OVF_PEND: begin
        if (wr_tima) begin
          // CPU write cancels the pending reload and its interrupt.
          tima_nxt  = wdata_in;
          state_nxt = RUN;
        end else if (tick_in) begin
          // A TMA write landing on the reload clock is forwarded directly.
          tima_nxt  = wr_tma ? wdata_in : tma;
          irq_nxt   = 1'b1;
          state_nxt = RUN;
        end else if (timer_fall) begin
          tima_nxt = tima + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    rdata_out = 8'h00;
    unique case (reg_sel)
      ADDR_DIV:  rdata_out = sys_cnt[15:8];
      ADDR_TIMA: rdata_out = tima;
      ADDR_TMA:  rdata_out = tma;
      ADDR_TAC:  rdata_out = {TAC_READ_PAD, tac};
    endcase
  end

  // The pulse is registered on the reload clock; the state returns to RUN at
  // the same edge, so it cannot repeat on the following clock.
  assign irq_out = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
// ---------------------------------------------------------------------------
// tb_gb_timer
// Self-checking bench for gb_timer. A behavioural reference model predicts
// all four registers and irq_out after every clock; predictions are queued
// when stimulus is driven and popped when the DUT has clocked. A vector table
// covers basic register access, and hand-written sequences cover the
// overflow, reload, cancel and edge-from-write corner cases.
// ---------------------------------------------------------------------------
module tb_gb_timer;

  localparam int unsigned STEP = 4;

  localparam logic [1:0] A_DIV  = 2'd0;
  localparam logic [1:0] A_TIMA = 2'd1;
  localparam logic [1:0] A_TMA  = 2'd2;
  localparam logic [1:0] A_TAC  = 2'd3;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       tick_in;
  logic [1:0] addr_in;
  logic       wr_en_in;
  logic [7:0] wdata_in;
  logic [7:0] rdata_out;
  logic       irq_out;

  always #10 clk_in = ~clk_in;

  gb_timer #(.CNT_STEP(STEP)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .tick_in   (tick_in),
    .addr_in   (addr_in),
    .wr_en_in  (wr_en_in),
    .wdata_in  (wdata_in),
    .rdata_out (rdata_out),
    .irq_out   (irq_out)
  );

  int checks = 0;
  int passed = 0;
  int step_no = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] div;
    logic [7:0] tima;
    logic [7:0] tma;
    logic [7:0] tac;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];

  int          tap_idx [4] = '{9, 3, 5, 7};
  logic [15:0] m_cnt  = '0;
  logic [2:0]  m_tac  = '0;
  logic [7:0]  m_tma  = '0;
  logic [7:0]  m_tima = '0;
  logic        m_pend = 1'b0;
  logic        m_prev = 1'b0;
  logic        m_irq  = 1'b0;

  task automatic model_clk(input logic r, input logic t, input logic w,
                           input logic [1:0] a, input logic [7:0] d);
    logic cur, fall;
    cur  = m_tac[2] && (((m_cnt >> tap_idx[m_tac[1:0]]) & 16'd1) != 16'd0);
    fall = m_prev && !cur;
    if (r) begin
      m_cnt = '0; m_tac = '0; m_tma = '0; m_tima = '0;
      m_pend = 1'b0; m_prev = 1'b0; m_irq = 1'b0;
    end else begin
      m_irq = 1'b0;
      if (w && a == A_TIMA) begin
        m_tima = d;
        m_pend = 1'b0;
      end else if (m_pend && t) begin
        m_tima = (w && a == A_TMA) ? d : m_tma;
        m_irq  = 1'b1;
        m_pend = 1'b0;
      end else if (fall) begin
        if (!m_pend && m_tima == 8'hFF) begin
          m_tima = 8'h00;
          m_pend = 1'b1;
        end else begin
          m_tima = m_tima + 8'd1;
        end
      end
      m_prev = cur;
      if (w && a == A_DIV) m_cnt = '0;
      else if (t)          m_cnt = m_cnt + 16'(STEP);
      if (w && a == A_TAC) m_tac = d[2:0];
      if (w && a == A_TMA) m_tma = d;
    end
  endtask

  // One clock: drive at negedge, queue the prediction, compare after posedge.
  // Returns at posedge+5; callers may do up to four 1-unit reads after it.
  task automatic step(input logic r, input logic t, input logic w,
                      input logic [1:0] a, input logic [7:0] d);
    exp_t e;
    logic [7:0] want;
    @(negedge clk_in);
    rst_in = r; tick_in = t; wr_en_in = w; addr_in = a; wdata_in = d;
    model_clk(r, t, w, a, d);
    e.div  = m_cnt[15:8];
    e.tima = m_tima;
    e.tma  = m_tma;
    e.tac  = {5'b11111, m_tac};
    e.irq  = m_irq;
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    step_no++;
    e = sb_q.pop_front();
    check($sformatf("sb_irq@%0d", step_no), {15'd0, irq_out}, {15'd0, e.irq});
    for (int k = 0; k < 4; k++) begin
      addr_in = 2'(k);
      #1;
      case (k)
        0:       want = e.div;
        1:       want = e.tima;
        2:       want = e.tma;
        default: want = e.tac;
      endcase
      check($sformatf("sb_reg%0d@%0d", k, step_no), {8'd0, rdata_out}, {8'd0, want});
    end
  endtask

  task automatic expect_reg(input string name, input logic [1:0] a, input logic [7:0] want);
    addr_in = a;
    #1;
    check(name, {8'd0, rdata_out}, {8'd0, want});
  endtask

  task automatic expect_irq(input string name, input logic want);
    check(name, {15'd0, irq_out}, {15'd0, want});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, A_DIV, 8'h00);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, A_DIV, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, A_DIV, 8'h00);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       tick;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [1:0] rd_addr;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t vecs [10];

  initial begin
    rst_in = 1'b1; tick_in = 1'b0; wr_en_in = 1'b0; addr_in = '0; wdata_in = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, A_DIV,  8'h00, A_TIMA, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, A_DIV,  8'h00, A_TAC,  8'hF8, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, A_TMA,  8'h5A, A_TMA,  8'h5A, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, A_TAC,  8'hFB, A_TAC,  8'hFB, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, A_TIMA, 8'h33, A_TIMA, 8'h33, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, A_DIV,  8'h99, A_DIV,  8'h00, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, A_DIV,  8'h00, A_TMA,  8'h5A, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, A_TAC,  8'h00, A_TAC,  8'hF8, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, A_TIMA, 8'hFF, A_TIMA, 8'hFF, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, A_DIV,  8'h00, A_TIMA, 8'hFF, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].tick, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      expect_reg($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rd);
      expect_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
    end

    // Overflow then reload: TAC=05 taps bit 3, so TIMA steps on ticks 5, 9, ...
    do_reset();
    wr(A_TAC, 8'h05); wr(A_TMA, 8'hAB); wr(A_TIMA, 8'hFE);
    for (int k = 1; k <= 11; k++) begin
      ticks(1);
      if (k == 8)  expect_reg("ovf_tima_ff", A_TIMA, 8'hFF);
      if (k == 9)  begin expect_reg("ovf_tima_00", A_TIMA, 8'h00); expect_irq("ovf_no_irq", 1'b0); end
      if (k == 10) begin expect_reg("ovf_reload", A_TIMA, 8'hAB); expect_irq("ovf_irq", 1'b1); end
      if (k == 11) begin expect_reg("ovf_hold", A_TIMA, 8'hAB); expect_irq("ovf_irq_1clk", 1'b0); end
    end

    // TIMA write while overflow is pending cancels reload and irq.
    do_reset();
    wr(A_TAC, 8'h05); wr(A_TIMA, 8'hFF);
    ticks(5);
    expect_reg("cancel_pend", A_TIMA, 8'h00);
    wr(A_TIMA, 8'h42);
    expect_reg("cancel_wr", A_TIMA, 8'h42);
    ticks(1);
    expect_reg("cancel_no_reload", A_TIMA, 8'h42);
    expect_irq("cancel_no_irq", 1'b0);
    ticks(1);
    expect_irq("cancel_no_irq2", 1'b0);

    // TMA write on the reload clock is loaded straight into TIMA.
    do_reset();
    wr(A_TAC, 8'h05); wr(A_TMA, 8'h11); wr(A_TIMA, 8'hFF);
    ticks(5);
    step(1'b0, 1'b1, 1'b1, A_TMA, 8'h99);
    expect_reg("tma_fwd_tima", A_TIMA, 8'h99);
    expect_irq("tma_fwd_irq", 1'b1);
    idle();
    expect_irq("tma_fwd_irq_off", 1'b0);

    // DIV write drops the tapped bit 9 from 1 to 0 and bumps TIMA.
    do_reset();
    wr(A_TAC, 8'h04); wr(A_TIMA, 8'h10);
    ticks(128);
    expect_reg("divwr_pre_div", A_DIV, 8'h02);
    step(1'b0, 1'b1, 1'b1, A_DIV, 8'h5C);
    expect_reg("divwr_div", A_DIV, 8'h00);
    expect_reg("divwr_tima_pre", A_TIMA, 8'h10);
    idle();
    expect_reg("divwr_tima_inc", A_TIMA, 8'h11);

    // Enable clear makes an edge; a TIMA write on that clock wins.
    ticks(2);
    wr(A_TAC, 8'h05);
    idle();
    wr(A_TAC, 8'h01);
    wr(A_TIMA, 8'h50);
    expect_reg("wr_prio_tima", A_TIMA, 8'h50);
    idle();
    expect_reg("wr_prio_hold", A_TIMA, 8'h50);

    // DIV write beats a same-clock tick: 1+63 ticks must leave DIV at 0.
    step(1'b0, 1'b1, 1'b1, A_DIV, 8'h00);
    ticks(63);
    expect_reg("div_prio_00", A_DIV, 8'h00);
    ticks(1);
    expect_reg("div_prio_01", A_DIV, 8'h01);

    // 64 ticks with bit 7 tapped.
    do_reset();
    wr(A_TAC, 8'h07);
    ticks(64);
    idle();
    expect_reg("b7_div", A_DIV, 8'h01);
    expect_reg("b7_tima", A_TIMA, 8'h01);
    expect_reg("b7_tac", A_TAC, 8'hFF);

    // Write-driven overflow, then an extra edge while pending advances TIMA.
    do_reset();
    wr(A_TAC, 8'h05); wr(A_TMA, 8'h3C);
    ticks(2);
    wr(A_TIMA, 8'hFF);
    wr(A_TAC, 8'h04);
    idle();
    expect_reg("pend_ovf", A_TIMA, 8'h00);
    wr(A_TAC, 8'h05);
    idle();
    wr(A_TAC, 8'h04);
    idle();
    expect_reg("pend_adv", A_TIMA, 8'h01);
    expect_irq("pend_adv_irq", 1'b0);
    ticks(1);
    expect_reg("pend_reload", A_TIMA, 8'h3C);
    expect_irq("pend_reload_irq", 1'b1);
    idle();
    expect_irq("pend_irq_off", 1'b0);

    // Reset while pending, with a tick and a write on the same clock.
    do_reset();
    wr(A_TAC, 8'h05); wr(A_TMA, 8'h77); wr(A_TIMA, 8'hFF);
    ticks(5);
    expect_reg("rst_pend", A_TIMA, 8'h00);
    step(1'b1, 1'b1, 1'b1, A_TIMA, 8'h55);
    expect_reg("rst_div", A_DIV, 8'h00);
    expect_reg("rst_tima", A_TIMA, 8'h00);
    expect_reg("rst_tma", A_TMA, 8'h00);
    expect_reg("rst_tac", A_TAC, 8'hF8);
    for (int k = 0; k < 3; k++) begin
      ticks(1);
      expect_irq($sformatf("rst_irq_%0d", k), 1'b0);
      expect_reg($sformatf("rst_tima_%0d", k), A_TIMA, 8'h00);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
